// File: rtl/w_addr_seq_gen_pkg.sv
// Shared FFT definitions: FSM state encodings, size limits and a clog2 helper
// used to size the twiddle address sequencer ports.
package w_addr_seq_gen_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    localparam int DEF_MIN_LOG2N = 2;

    // Returns ceil(log2(value)); a width of at least one bit is always produced.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/w_addr_seq_gen_if.sv
// Handshake and status bundle between an FFT controller (master) and the
// twiddle address sequencer (slave).
interface w_addr_seq_gen_if
    import w_addr_seq_gen_pkg::*;
#(
    parameter int AWL = 5
) ();

    logic                        START;
    logic [clog2(AWL + 1) - 1:0] LOG2N;
    logic                        INV;
    logic                        EN;
    logic [AWL - 2:0]            W_ADDR;
    logic                        W_VALID;
    logic                        W_CONJ;
    logic [clog2(AWL) - 1:0]     LAYER;
    logic                        LAST_BFLY;
    logic                        DONE;
    logic                        BUSY;
    logic                        ERR;

    modport master (
        output START, LOG2N, INV, EN,
        input  W_ADDR, W_VALID, W_CONJ, LAYER, LAST_BFLY, DONE, BUSY, ERR
    );

    modport slave (
        input  START, LOG2N, INV, EN,
        output W_ADDR, W_VALID, W_CONJ, LAYER, LAST_BFLY, DONE, BUSY, ERR
    );

endinterface

// File: rtl/w_addr_seq_gen_param_register.sv
// Generic width-parameterised register with load enable and synchronous
// active-high reset to a parameterised value.
module param_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/w_addr_seq_gen.sv
// Twiddle-factor address sequencer for a radix-2 FFT: walks L layers of
// 2^(L-1) butterflies, stepping the table address by 2^(AWL-1-s) in layer s.
module w_addr_seq_gen
    import w_addr_seq_gen_pkg::*;
#(
    parameter int AWL       = 5,
    parameter int MIN_LOG2N = DEF_MIN_LOG2N
) (
    input  logic              CLK,
    input  logic              RST,
    w_addr_seq_gen_if.slave   bus
);

    localparam int AW = AWL - 1;
    localparam int LW = clog2(AWL + 1);
    localparam int SW = clog2(AWL);

    fsm_state_t    state_q, state_d;
    logic [LW-1:0] l_q, l_d;
    logic          inv_q, inv_d;
    logic [SW-1:0] s_q, s_d;
    logic [AW-1:0] b_q, b_d;
    logic          err_q, err_d;

    logic [AW-1:0]  addr_q, addr_d;
    logic           addr_en;
    logic           start_ok;
    logic           last_bfly;
    logic           last_layer;
    logic [AW-1:0]  b_last;
    logic [AWL-1:0] step;
    logic [AW-1:0]  addr_next;

    assign start_ok = (bus.LOG2N >= LW'(MIN_LOG2N)) && (bus.LOG2N <= LW'(AWL));

    // Butterflies per layer minus one; the AWL-bit intermediate keeps 2^(AWL-1) exact.
    assign b_last     = AW'((AWL'(1) << (l_q - LW'(1))) - AWL'(1));
    assign last_bfly  = (state_q == ST_RUN) && (b_q == b_last);
    assign last_layer = (s_q == SW'(l_q - LW'(1)));

    // Layer 0 steps by 2^(AWL-1), which wraps to zero in the AW-bit address.
    assign step      = AWL'(1) << (SW'(AW) - s_q);
    assign addr_next = AW'(AWL'(addr_q) + step);

    assign addr_en = ((state_q == ST_RUN) && bus.EN) ||
                     ((state_q == ST_IDLE) && bus.START && start_ok);

    // NOTE: every _d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        inv_d   = inv_q;
        s_d     = s_q;
        b_d     = b_q;
        err_d   = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    if (start_ok) begin
                        l_d     = bus.LOG2N;
                        inv_d   = bus.INV;
                        s_d     = '0;
                        b_d     = '0;
                        addr_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.EN) begin
                    if (last_bfly) begin
                        b_d    = '0;
                        addr_d = '0;
                        if (last_layer) begin
                            state_d = ST_DONE;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end else begin
                        b_d    = b_q + AW'(1);
                        addr_d = addr_next;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            inv_q   <= 1'b0;
            s_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            inv_q   <= inv_d;
            s_q     <= s_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    param_register #(
        .WIDTH       (AW),
        .RESET_VALUE ('0)
    ) u_addr_reg (
        .clk  (CLK),
        .rst  (RST),
        .en_i (addr_en),
        .d_i  (addr_d),
        .q_o  (addr_q)
    );

    assign bus.W_ADDR    = addr_q;
    assign bus.W_VALID   = (state_q == ST_RUN);
    assign bus.W_CONJ    = inv_q;
    assign bus.LAYER     = s_q;
    assign bus.LAST_BFLY = last_bfly;
    assign bus.DONE      = (state_q == ST_DONE);
    assign bus.BUSY      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_w_addr_seq_gen.sv
// Scoreboard bench for w_addr_seq_gen (AWL=5): stimulus pushes expected
// butterflies/DONE/ERR events, a negedge monitor pops and compares them.
module tb_w_addr_seq_gen;

    typedef enum int {K_BFLY, K_DONE, K_ERR} kind_t;

    typedef struct {
        kind_t kind;
        int    addr;
        int    layer;
        bit    last;
        bit    conj;
    } exp_t;

    logic CLK;
    logic RST;

    w_addr_seq_gen_if #(.AWL(5)) bus ();

    w_addr_seq_gen #(.AWL(5), .MIN_LOG2N(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   vectors       = 0;
    int   miscompares   = 0;
    int   cyc_cnt       = 0;
    int   last_bfly_cyc = 0;
    int   bfly_cnt      = 0;
    int   err_seen      = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic underflow(input string what);
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: DUT presented %s with nothing expected (t=%0t)", what, $time);
    endtask

    // Hand tables for L=2 and L=3; larger sizes use (b mod 2^s) * 2^(4-s).
    task automatic push_transform(input int l, input bit conj);
        int   l2_tab [4];
        int   l3_tab [12];
        int   half;
        exp_t e;
        l2_tab = '{0, 0, 0, 8};
        l3_tab = '{0, 0, 0, 0, 0, 8, 0, 8, 0, 4, 8, 12};
        half   = 1 << (l - 1);
        for (int s = 0; s < l; s++) begin
            for (int b = 0; b < half; b++) begin
                e.kind  = K_BFLY;
                e.layer = s;
                e.last  = (b == half - 1);
                e.conj  = conj;
                if (l == 2)      e.addr = l2_tab[s * half + b];
                else if (l == 3) e.addr = l3_tab[s * half + b];
                else             e.addr = (b % (1 << s)) * (1 << (4 - s));
                sb_q.push_back(e);
            end
        end
        e.kind = K_DONE; e.addr = 0; e.layer = l - 1; e.last = 1'b0; e.conj = conj;
        sb_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        cyc_cnt++;
        if (RST === 1'b0) begin
            if (bus.W_VALID === 1'b1) begin
                if (sb_q.size() == 0) begin
                    underflow("a butterfly");
                end else if (bus.EN === 1'b1) begin
                    e = sb_q.pop_front();
                    check("bfly_kind", int'(K_BFLY), int'(e.kind));
                    check("bfly_addr", int'(bus.W_ADDR), e.addr);
                    check("bfly_layer", int'(bus.LAYER), e.layer);
                    check("bfly_last", int'(bus.LAST_BFLY), int'(e.last));
                    check("bfly_conj", int'(bus.W_CONJ), int'(e.conj));
                    last_bfly_cyc = cyc_cnt;
                    bfly_cnt++;
                end else begin
                    e = sb_q[0];
                    check("hold_addr", int'(bus.W_ADDR), e.addr);
                    check("hold_layer", int'(bus.LAYER), e.layer);
                end
            end
            if (bus.DONE === 1'b1) begin
                if (sb_q.size() == 0) begin
                    underflow("DONE");
                end else begin
                    e = sb_q.pop_front();
                    check("done_kind", int'(K_DONE), int'(e.kind));
                    check("done_latency", cyc_cnt - last_bfly_cyc, 1);
                    check("done_valid", int'(bus.W_VALID), 0);
                    check("done_busy", int'(bus.BUSY), 1);
                end
            end
            if (bus.ERR === 1'b1) begin
                err_seen++;
                if (sb_q.size() == 0) begin
                    underflow("ERR");
                end else begin
                    e = sb_q.pop_front();
                    check("err_kind", int'(K_ERR), int'(e.kind));
                    check("err_busy", int'(bus.BUSY), 0);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_w_addr"}, int'(bus.W_ADDR), 0);
        check({tag, "_w_valid"}, int'(bus.W_VALID), 0);
        check({tag, "_w_conj"}, int'(bus.W_CONJ), 0);
        check({tag, "_layer"}, int'(bus.LAYER), 0);
        check({tag, "_last_bfly"}, int'(bus.LAST_BFLY), 0);
        check({tag, "_done"}, int'(bus.DONE), 0);
        check({tag, "_busy"}, int'(bus.BUSY), 0);
        check({tag, "_err"}, int'(bus.ERR), 0);
    endtask

    // Caller is positioned just after a rising edge.
    task automatic start_xfer(input int l, input bit inv);
        bus.START = 1'b1;
        bus.LOG2N = 3'(l);
        bus.INV   = inv;
        bus.EN    = 1'b0;
        bfly_cnt  = 0;
        push_transform(l, inv);
    endtask

    // mode 0: EN held high; mode 1: EN pattern 1,0,0,1. toggle scrambles INV/LOG2N,
    // poke raises an out-of-range START mid-run.
    task automatic wait_done(input int l, input int mode, input bit toggle, input bit poke);
        int  budget;
        bit  seen;
        budget = l * (1 << (l - 1)) * 4 + 10;
        seen   = 1'b0;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            bus.EN = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (toggle) begin
                bus.INV   = ~bus.INV;
                bus.LOG2N = 3'(cyc % 8);
            end
            if (poke) begin
                bus.START = (cyc == 2);
                bus.LOG2N = (cyc == 2) ? 3'd6 : 3'(l);
            end
            @(negedge CLK);
            if (bus.DONE === 1'b1) begin
                seen = 1'b1;
                check("done_layer", int'(bus.LAYER), l - 1);
                check("en_cycles", bfly_cnt, l * (1 << (l - 1)));
                break;
            end
            @(posedge CLK); #1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no DONE within %0d cycles for L=%0d", budget, l);
        end
        @(posedge CLK); #1;
        bus.EN    = 1'b0;
        bus.START = 1'b0;
        bus.INV   = 1'b0;
        @(negedge CLK);
        check("post_done", int'(bus.DONE), 0);
        check("post_busy", int'(bus.BUSY), 0);
        check("post_valid", int'(bus.W_VALID), 0);
    endtask

    task automatic bad_start(input int l);
        exp_t e;
        @(posedge CLK); #1;
        bus.START = 1'b1;
        bus.LOG2N = 3'(l);
        e.kind = K_ERR; e.addr = 0; e.layer = 0; e.last = 1'b0; e.conj = 1'b0;
        sb_q.push_back(e);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (2) @(negedge CLK);
        check("err_no_busy", int'(bus.BUSY), 0);
    endtask

    initial begin
        int n;
        RST       = 1'b1;
        bus.START = 1'b0;
        bus.LOG2N = '0;
        bus.INV   = 1'b0;
        bus.EN    = 1'b0;
        @(posedge CLK); #1;
        bus.START = 1'b1;
        bus.EN    = 1'b1;
        bus.LOG2N = 3'd3;
        @(negedge CLK);
        check_idle_outputs("reset");
        @(posedge CLK); #1;
        RST       = 1'b0;
        bus.START = 1'b0;
        bus.EN    = 1'b0;

        // L=3 with EN held high.
        @(posedge CLK); #1; start_xfer(3, 1'b0);
        wait_done(3, 0, 1'b0, 1'b0);

        // L=5: full size, 80 EN cycles.
        @(posedge CLK); #1; start_xfer(5, 1'b0);
        wait_done(5, 0, 1'b0, 1'b0);

        // L=3 with gapped EN.
        @(posedge CLK); #1; start_xfer(3, 1'b0);
        wait_done(3, 1, 1'b0, 1'b0);

        // Out-of-range sizes.
        bad_start(6);
        bad_start(1);
        check("err_pulses", err_seen, 2);

        // Smallest size with a START issued during RUN.
        @(posedge CLK); #1; start_xfer(2, 1'b0);
        wait_done(2, 0, 1'b0, 1'b1);
        check("err_after_poke", err_seen, 2);

        // Inverse transform with INV/LOG2N wiggled during RUN, then forward again.
        @(posedge CLK); #1; start_xfer(3, 1'b1);
        wait_done(3, 0, 1'b1, 1'b0);
        @(posedge CLK); #1; start_xfer(2, 1'b0);
        wait_done(2, 0, 1'b0, 1'b0);

        // Reset in layer 1 of an L=4 transform, then an immediate START.
        @(posedge CLK); #1; start_xfer(4, 1'b1);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        bus.EN    = 1'b1;
        n = 0;
        while (n < 100 && !(bus.W_VALID === 1'b1 && bus.LAYER == 1)) begin
            @(negedge CLK);
            n++;
        end
        check("reach_layer1", int'(n < 100), 1);
        @(posedge CLK); #1;
        RST    = 1'b1;
        bus.EN = 1'b0;
        @(posedge CLK); #1;
        sb_q.delete();
        RST = 1'b0;
        start_xfer(2, 1'b0);
        @(negedge CLK);
        check_idle_outputs("midrst");
        wait_done(2, 0, 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
